// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / ID-branch stalls, EX/ID forwarding, MDU stall sequencer.
// Define HAZARD_PERF_EN to add the saturating stall_cyc / mdu_cyc / bubble_cnt counters.
module hazard_ctrl #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32
`ifdef HAZARD_PERF_EN
  ,
  parameter int unsigned PERF_W  = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] wreg_e,
  input  logic [REG_AW-1:0] wreg_m,
  input  logic [REG_AW-1:0] wreg_w,
  input  logic              we_e,
  input  logic              we_m,
  input  logic              we_w,
  input  logic              mem_to_reg_e,
  input  logic              mem_to_reg_m,
  input  logic              branch_d,
  input  logic              mdu_start_e,
  input  logic              mdu_div_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              flush_e,
  output logic              flush_m,
  output logic              fwd_a_d,
  output logic              fwd_b_d,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              mdu_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cyc,
  output logic [PERF_W-1:0] mdu_cyc,
  output logic [PERF_W-1:0] bubble_cnt
`endif
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lw_stall_c, br_stall_c, mdu_stall_c;
  logic               wr_e_hit_c, ld_m_hit_c;

  // Register 0 is never a hazard source.
  assign wr_e_hit_c = we_e & (wreg_e != '0) & ((wreg_e == rs_d) | (wreg_e == rt_d));
  assign ld_m_hit_c = mem_to_reg_m & (wreg_m != '0) & ((wreg_m == rs_d) | (wreg_m == rt_d));
  assign lw_stall_c = mem_to_reg_e & (rt_e != '0) & ((rs_d == rt_e) | (rt_d == rt_e));
  assign br_stall_c = branch_d & (wr_e_hit_c | ld_m_hit_c);

  // MDU sequencer state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: start is ignored while BUSY so the releasing op cannot retrigger.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (mdu_start_e) begin
          state_d = S_BUSY;
          cnt_d   = mdu_div_e ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else             state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stall/flush outputs; MDU holds EX so it outranks lw/branch hazards.
  always_comb begin
    mdu_stall_c = ((state_q == S_IDLE) & mdu_start_e) | ((state_q == S_BUSY) & (cnt_q != '0));
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    flush_e     = 1'b0;
    flush_m     = 1'b0;
    mdu_busy    = 1'b0;
    if (rst_n) begin
      mdu_busy = (state_q == S_BUSY);
      if (mdu_stall_c) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
      end else if (lw_stall_c | br_stall_c) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  // Forward selects stay live through reset; MEM outranks WB.
  always_comb begin
    fwd_a_e = 2'b00;
    fwd_b_e = 2'b00;
    if (we_m & (wreg_m != '0) & (wreg_m == rs_e))      fwd_a_e = 2'b10;
    else if (we_w & (wreg_w != '0) & (wreg_w == rs_e)) fwd_a_e = 2'b01;
    if (we_m & (wreg_m != '0) & (wreg_m == rt_e))      fwd_b_e = 2'b10;
    else if (we_w & (wreg_w != '0) & (wreg_w == rt_e)) fwd_b_e = 2'b01;
    fwd_a_d = we_m & (wreg_m != '0) & (wreg_m == rs_d);
    fwd_b_d = we_m & (wreg_m != '0) & (wreg_m == rt_d);
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cyc_q, mdu_cyc_q, bubble_cnt_q;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cyc_q  <= '0;
      mdu_cyc_q    <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (stall_f && (stall_cyc_q != '1))           stall_cyc_q  <= stall_cyc_q + PERF_W'(1);
      if (mdu_stall_c && (mdu_cyc_q != '1))         mdu_cyc_q    <= mdu_cyc_q + PERF_W'(1);
      if ((flush_e | flush_m) && (bubble_cnt_q != '1)) bubble_cnt_q <= bubble_cnt_q + PERF_W'(1);
    end
  end

  assign stall_cyc  = stall_cyc_q;
  assign mdu_cyc    = mdu_cyc_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core; successor to the combinational stall unit. It resolves load-use and ID-stage branch-compare hazards and generates EX/ID forwarding selects. It also adds a multi-cycle multiply/divide (MDU) stall sequencer with a latency counter. It sits beside the datapath and drives the F/D/E stage-register enables and the E/M bubble inserts.

## Interface
Parameters:
- REG_AW, 5, register-address width
- MUL_LAT, 4, multiply latency in cycles (>=1)
- DIV_LAT, 32, divide latency in cycles (>=1)
- PERF_W, 32, performance-counter width (used only with HAZARD_PERF_EN)

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- rs_d, rt_d  in  REG_AW  source registers of the instruction in ID
- rs_e, rt_e  in  REG_AW  source registers of the instruction in EX
- wreg_e, wreg_m, wreg_w  in  REG_AW  destination register in EX/MEM/WB
- we_e, we_m, we_w  in  1  regfile write enable in EX/MEM/WB
- mem_to_reg_e, mem_to_reg_m  in  1  load instruction in EX/MEM
- branch_d  in  1  ID instruction compares registers in ID (beq/bne/jr)
- mdu_start_e  in  1  mul/div instruction present in EX
- mdu_div_e  in  1  1 = divide, 0 = multiply (valid with mdu_start_e)
- stall_f, stall_d, stall_e  out  1  hold PC / IF-ID / ID-EX registers
- flush_e, flush_m  out  1  insert bubble into ID-EX / EX-MEM
- fwd_a_d, fwd_b_d  out  1  ID compare operand from MEM result
- fwd_a_e, fwd_b_e  out  2  EX operand: 00 regfile, 01 WB, 10 MEM
- mdu_busy  out  1  MDU sequencer in BUSY

## Operation
- Register 0 never matches any hazard or forward term.
- lw_stall = mem_to_reg_e & rt_e!=0 & (rs_d==rt_e | rt_d==rt_e).
- br_stall = branch_d & [(we_e & wreg_e!=0 & wreg_e∈{rs_d,rt_d}) | (mem_to_reg_m & wreg_m!=0 & wreg_m∈{rs_d,rt_d})].
- fwd_a_e: 10 if we_m & wreg_m!=0 & wreg_m==rs_e; else 01 if we_w & wreg_w!=0 & wreg_w==rs_e; else 00. MEM has priority over WB. fwd_b_e is the same with rt_e.
- fwd_a_d = we_m & wreg_m!=0 & wreg_m==rs_d. fwd_b_d is the same with rt_d.
- MDU FSM states:
  - IDLE: if mdu_start_e, load cnt = (mdu_div_e ? DIV_LAT : MUL_LAT) - 1 and go to BUSY.
  - BUSY: if cnt!=0, decrement cnt; else go to IDLE.
  - mdu_start_e is ignored while in BUSY. This covers the releasing instruction still present in EX.
- mdu_stall = (IDLE & mdu_start_e) | (BUSY & cnt!=0). Total stall = LAT cycles.
- Output priority:
  - If mdu_stall: stall_f = stall_d = stall_e = 1, flush_m = 1, flush_e = 0. EX is held, so a concurrent lw/branch hazard waits.
  - Else if lw_stall | br_stall: stall_f = stall_d = 1, flush_e = 1, stall_e = 0, flush_m = 0.
  - Else: all stall/flush outputs = 0.
- mdu_busy = (state == BUSY).
- cnt width = clog2(max(MUL_LAT, DIV_LAT)).

## Timing
- Hazard, stall and forward outputs are combinational from the inputs and the current FSM state, with zero latency.
- FSM and cnt update on the rising clk edge.
- Reset:
  - rst_n=0 at a clk edge sets state = IDLE and cnt = 0.
  - While rst_n=0, stall_*, flush_* and mdu_busy are forced to 0. Forward selects stay live.
- Reset mid-BUSY aborts the sequence. The next cycle after rst_n rises is IDLE.
- With LAT = 1: one stall cycle in IDLE, one BUSY cycle with cnt = 0 and no stall, then IDLE.
- Back-to-back MDU ops: the second op's mdu_start_e is seen in IDLE on the cycle after BUSY exits, and a new sequence starts.

## Configuration
- HAZARD_PERF_EN defined:
  - Adds outputs stall_cyc (PERF_W), mdu_cyc (PERF_W) and bubble_cnt (PERF_W).
  - All three are saturating counters, reset to 0.
  - stall_cyc increments on every cycle with stall_f = 1.
  - mdu_cyc increments on every mdu_stall cycle.
  - bubble_cnt increments on every flush_e | flush_m cycle.
- Undefined: these ports and registers are absent, and behaviour is otherwise identical.

## Test plan
- Load-use: mem_to_reg_e=1, rt_e=8, rs_d=8 -> stall_f = stall_d = flush_e = 1, stall_e = 0. Repeat with rt_e=0 -> all 0.
- Branch hazard: branch_d=1, we_e=1, wreg_e=9, rt_d=9 -> one stall. Then mem_to_reg_m=1, wreg_m=9 -> stall. With we_m=1 and no load -> no stall, fwd_b_d = 1.
- Forwarding priority: we_m = we_w = 1, wreg_m = wreg_w = rs_e = 3 -> fwd_a_e = 10. Clear we_m -> fwd_a_e = 01.
- Divide with DIV_LAT=32: pulse mdu_start_e held with mdu_div_e=1 -> exactly 32 cycles of stall_e = 1 and flush_m = 1. mdu_busy high for 32 cycles, then release. Concurrent lw_stall during the window -> flush_e stays 0.
- Reset mid-BUSY: drive rst_n=0 at cycle 10 of a divide -> next edge IDLE, outputs 0, mdu_busy = 0. A multiply after release -> 4 stall cycles.
- HAZARD_PERF_EN: run one divide (32 cycles) and one load-use stall -> stall_cyc = 33, mdu_cyc = 32, bubble_cnt = 33. Preload near saturation -> counters hold at all-ones.
